chacha_ctrl: RTL and testbench

- Sequencer for the ChaCha20 block core. It accepts the byte-serial key, nonce and counter loads and forwards them as addressed state-byte writes.
- It steps the quarter-round datapath through ROUNDS alternating column/diagonal rounds, then triggers the final feed-forward add.
- It owns blk_ready and the 64-byte readout sequence. After each block is read it requests a counter increment and starts the next block automatically.

---
 rtl/chacha_ctrl.sv | 171 +++++++++++++++++
 tb/tb_chacha_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/chacha_ctrl.sv
// ChaCha20 block sequencer: forwards byte-serial key/nonce/counter loads, steps
// the quarter-round datapath through the rounds, and runs the 64-byte readout.
module chacha_ctrl #(
  parameter int ROUNDS   = 20,
  parameter int RD_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_key,
  input  logic       wr_nnc,
  input  logic       wr_ctr,
  input  logic       rd_blk,
  input  logic [7:0] data_in,
  input  logic       qr_done,
  output logic       ld_en,
  output logic [5:0] ld_addr,
  output logic [7:0] ld_data,
  output logic       qr_go,
  output logic       qr_diag,
  output logic [4:0] rnd_idx,
  output logic       fin_go,
  output logic       blk_ready,
  output logic       rd_en,
  output logic [5:0] rd_addr,
  output logic       ctr_inc,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, FIN, FWAIT, READY, READ} state_t;

  localparam logic [4:0] LAST_RND  = 5'(ROUNDS - 1);
  localparam logic [5:0] LAST_BYTE = 6'(RD_BYTES - 1);

  state_t     state;
  logic       key_v, nnc_v, ctr_v;
  logic [5:0] cnt;
  logic [1:0] region;
  logic       rd_blk_q;

  logic       wr_any, rd_req;
  logic [1:0] ld_sel;
  logic [5:0] ld_base, ld_len;

  assign wr_any = wr_key | wr_nnc | wr_ctr;
  // A held rd_blk counts once: only its rising edge requests a readout.
  assign rd_req = rd_blk & ~rd_blk_q;

  always_comb begin
    ld_sel  = 2'd2;
    ld_base = 6'd48;
    ld_len  = 6'd4;
    if (wr_key) begin
      ld_sel  = 2'd0;
      ld_base = 6'd16;
      ld_len  = 6'd32;
    end else if (wr_nnc) begin
      ld_sel  = 2'd1;
      ld_base = 6'd52;
      ld_len  = 6'd12;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_v     <= 1'b0;
      nnc_v     <= 1'b0;
      ctr_v     <= 1'b0;
      cnt       <= '0;
      region    <= '0;
      rd_blk_q  <= 1'b0;
      ld_en     <= 1'b0;
      ld_addr   <= '0;
      ld_data   <= '0;
      qr_go     <= 1'b0;
      qr_diag   <= 1'b0;
      rnd_idx   <= '0;
      fin_go    <= 1'b0;
      blk_ready <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      ctr_inc   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ld_en    <= 1'b0;
      qr_go    <= 1'b0;
      fin_go   <= 1'b0;
      rd_en    <= 1'b0;
      ctr_inc  <= 1'b0;
      rd_blk_q <= rd_blk;
      case (state)
        IDLE, READY: begin
          if (wr_any) begin
            state     <= LOAD;
            region    <= ld_sel;
            cnt       <= ld_len - 6'd1;
            ld_en     <= 1'b1;
            ld_addr   <= ld_base;
            ld_data   <= data_in;
            blk_ready <= 1'b0;
            busy      <= 1'b1;
          end else if (state == IDLE && key_v && nnc_v && ctr_v) begin
            state   <= ISSUE;
            rnd_idx <= '0;
            qr_go   <= 1'b1;
            qr_diag <= 1'b0;
            busy    <= 1'b1;
          end else if (state == READY && rd_req) begin
            state   <= READ;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          ld_en   <= 1'b1;
          ld_data <= data_in;
          ld_addr <= ld_addr + 6'd1;
          cnt     <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            case (region)
              2'd0:    key_v <= 1'b1;
              2'd1:    nnc_v <= 1'b1;
              default: ctr_v <= 1'b1;
            endcase
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (qr_done) begin
            if (rnd_idx < LAST_RND) begin
              state   <= ISSUE;
              rnd_idx <= rnd_idx + 5'd1;
              qr_go   <= 1'b1;
              qr_diag <= ~rnd_idx[0];
            end else begin
              state  <= FIN;
              fin_go <= 1'b1;
            end
          end
        end
        FIN: state <= FWAIT;
        FWAIT: begin
          if (qr_done) begin
            state     <= READY;
            blk_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        READ: begin
          if (rd_addr == LAST_BYTE) begin
            // Next block starts straight away with the incremented counter.
            state     <= ISSUE;
            ctr_inc   <= 1'b1;
            blk_ready <= 1'b0;
            rnd_idx   <= '0;
            qr_go     <= 1'b1;
            qr_diag   <= 1'b0;
          end else begin
            rd_en   <= 1'b1;
            rd_addr <= rd_addr + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_ctrl.sv
// Directed bench for chacha_ctrl: loads, round sequencing, readout, load/read
// contention and reset in the middle of a block.
module tb_chacha_ctrl;

  localparam int ROUNDS   = 20;
  localparam int RD_BYTES = 64;

  logic       clk = 1'b0;
  logic       rst_n, wr_key, wr_nnc, wr_ctr, rd_blk, qr_done;
  logic [7:0] data_in;
  logic       ld_en, qr_go, qr_diag, fin_go, blk_ready, rd_en, ctr_inc, busy;
  logic [5:0] ld_addr, rd_addr;
  logic [7:0] ld_data;
  logic [4:0] rnd_idx;

  int n_chk  = 0;
  int n_fail = 0;

  chacha_ctrl #(.ROUNDS(ROUNDS), .RD_BYTES(RD_BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .wr_key(wr_key), .wr_nnc(wr_nnc), .wr_ctr(wr_ctr),
    .rd_blk(rd_blk), .data_in(data_in), .qr_done(qr_done), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .qr_go(qr_go), .qr_diag(qr_diag),
    .rnd_idx(rnd_idx), .fin_go(fin_go), .blk_ready(blk_ready), .rd_en(rd_en),
    .rd_addr(rd_addr), .ctr_inc(ctr_inc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check_zero_outs(input string tag);
    check(tag, {ld_en, ld_addr, ld_data, qr_go, qr_diag, rnd_idx, fin_go,
                blk_ready, rd_en, rd_addr, ctr_inc, busy}, 64'd0);
  endtask

  task automatic do_load(input int kind, input int n, input int base,
                         input logic [7:0] b0, input logic step, input logic combo);
    logic [7:0] exp_b;
    for (int i = 0; i < n; i++) begin
      exp_b   = step ? b0 + 8'(i) : ((i == 0) ? b0 : 8'h00);
      data_in = exp_b;
      wr_key  = (i == 0) && (kind == 0);
      wr_nnc  = (i == 0) && (kind == 1);
      wr_ctr  = (i == 0) && ((kind == 2) || combo);
      rd_blk  = (i == 0) && combo;
      cyc();
      check("ld_en", ld_en, 1);
      check("ld_addr", ld_addr, 64'(base + i));
      check("ld_data", ld_data, exp_b);
      check("qr_go_in_load", qr_go, 0);
      if (combo) begin
        check("rd_en_combo", rd_en, 0);
        check("blk_ready_combo", blk_ready, 0);
      end
    end
    wr_key = 0; wr_nnc = 0; wr_ctr = 0; rd_blk = 0; data_in = 8'h00;
  endtask

  // Answers each qr_go with qr_done three cycles later; stops at round 'stop'.
  task automatic run_rounds(input int stop, input logic glitch);
    int n;
    for (int r = 0; r < ROUNDS; r++) begin
      n = 0;
      while (!qr_go && n < 12) begin
        cyc();
        n++;
      end
      check("qr_go_seen", qr_go, 1);
      check("rnd_idx", rnd_idx, 64'(r));
      check("qr_diag", qr_diag, 64'(r % 2));
      check("busy_round", busy, 1);
      if (r == stop) return;
      qr_done = glitch && (r == 0);
      cyc();
      qr_done = 0;
      check("go_spacing", qr_go, 0);
      check("ctr_inc_once", ctr_inc, 0);
      cyc();
      check("rnd_hold", rnd_idx, 64'(r));
      qr_done = 1;
      cyc();
      qr_done = 0;
    end
    check("fin_go", fin_go, 1);
    check("no_go_at_fin", qr_go, 0);
    cyc();
    check("fin_go_pulse", fin_go, 0);
    cyc();
    check("blk_ready_early", blk_ready, 0);
    qr_done = 1;
    cyc();
    qr_done = 0;
    check("blk_ready", blk_ready, 1);
    check("busy_ready", busy, 0);
  endtask

  initial begin
    rst_n = 0; wr_key = 0; wr_nnc = 0; wr_ctr = 0; rd_blk = 0; qr_done = 0; data_in = 8'h00;
    repeat (3) cyc();
    check_zero_outs("reset_outs");
    rst_n = 1;

    // Reset in the middle of a key load aborts it.
    data_in = 8'h55; wr_key = 1;
    cyc();
    wr_key = 0;
    cyc(); cyc();
    rst_n = 0;
    cyc();
    check_zero_outs("midload_reset_outs");
    rst_n = 1;
    cyc();
    check("ld_en_after_reset", ld_en, 0);

    do_load(0, 32, 16, 8'h00, 1'b1, 1'b0);
    cyc();
    check("ld_en_end_key", ld_en, 0);
    check("busy_after_key", busy, 0);
    cyc();
    check("no_go_key_only", qr_go, 0);

    do_load(1, 12, 52, 8'h40, 1'b1, 1'b0);
    cyc();
    check("no_go_key_nnc", qr_go, 0);

    do_load(2, 4, 48, 8'h01, 1'b0, 1'b0);
    run_rounds(-1, 1'b0);

    rd_blk = 1;
    for (int i = 0; i < RD_BYTES; i++) begin
      cyc();
      if (i == 1) rd_blk = 0;
      check("rd_en", rd_en, 1);
      check("rd_addr", rd_addr, 64'(i));
      check("ctr_inc_during_read", ctr_inc, 0);
    end
    cyc();
    check("rd_en_end", rd_en, 0);
    check("ctr_inc", ctr_inc, 1);
    check("blk_ready_after_read", blk_ready, 0);
    check("qr_go_next_blk", qr_go, 1);
    check("rnd_idx_next_blk", rnd_idx, 0);
    run_rounds(-1, 1'b1);

    // wr_key + wr_ctr + rd_blk in READY: only the key load happens.
    do_load(0, 32, 16, 8'hA0, 1'b1, 1'b1);
    run_rounds(7, 1'b0);
    rst_n = 0;
    cyc();
    check_zero_outs("round7_reset_outs");
    rst_n = 1;

    do_load(0, 32, 16, 8'h10, 1'b1, 1'b0);
    do_load(1, 12, 52, 8'h60, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("no_go_ctr_missing", qr_go, 0);
      check("idle_not_busy", busy, 0);
    end
    do_load(2, 4, 48, 8'h07, 1'b0, 1'b0);
    run_rounds(-1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
